// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter that multiplexes per-channel memory commands onto one downstream port.
// Long commands are issued as segments of at most MAX_SEGMENT words, one segment at a time.
module mem_channel_arbiter #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned LEN_WIDTH    = 32,
    parameter int unsigned MAX_SEGMENT  = 64
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [NUM_CHANNELS-1:0]                              ch_cmd_enable,
    output logic [NUM_CHANNELS-1:0]                              ch_cmd_ready,
    input  logic [NUM_CHANNELS*(1+ADDR_WIDTH+LEN_WIDTH)-1:0]     ch_cmd_data,
    input  logic [NUM_CHANNELS-1:0]                              ch_write_enable,
    output logic [NUM_CHANNELS-1:0]                              ch_write_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]                   ch_write_data,
    output logic [NUM_CHANNELS-1:0]                              ch_read_enable,
    input  logic [NUM_CHANNELS-1:0]                              ch_read_ready,
    output logic [DATA_WIDTH-1:0]                                ch_read_data,
    output logic                                                 mem_cmd_enable,
    input  logic                                                 mem_cmd_ready,
    output logic [ADDR_WIDTH+LEN_WIDTH:0]                        mem_cmd_data,
    output logic                                                 mem_write_enable,
    input  logic                                                 mem_write_ready,
    output logic [DATA_WIDTH-1:0]                                mem_write_data,
    input  logic                                                 mem_read_enable,
    output logic                                                 mem_read_ready,
    input  logic [DATA_WIDTH-1:0]                                mem_read_data,
    output logic                                                 grant_valid,
    output logic [$clog2(NUM_CHANNELS)-1:0]                      grant_index
);

    localparam int unsigned CW = 1 + ADDR_WIDTH + LEN_WIDTH;
    localparam int unsigned GW = $clog2(NUM_CHANNELS);

    typedef enum logic [1:0] {StArb, StIssue, StWrite, StRead} state_e;

    state_e                  state_q;
    logic                    running_q;
    logic [NUM_CHANNELS-1:0] pending_q;
    logic [NUM_CHANNELS-1:0] rnw_q;
    logic [ADDR_WIDTH-1:0]   addr_q   [NUM_CHANNELS];
    logic [LEN_WIDTH-1:0]    remain_q [NUM_CHANNELS];
    logic [GW-1:0]           grant_q;
    logic [GW-1:0]           last_grant_q;
    logic [LEN_WIDTH-1:0]    seg_len_q;
    logic [LEN_WIDTH-1:0]    count_q;

    logic                    found;
    logic [GW-1:0]           pick;
    logic [LEN_WIDTH-1:0]    pick_len;
    logic                    data_xfer;
    logic                    seg_done;
    int                      idx;

    assign ch_cmd_ready = {NUM_CHANNELS{running_q}} & ~pending_q;

    // Search starts just after the last granted channel so every pending channel gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= int'(NUM_CHANNELS); k++) begin
            idx = (int'(last_grant_q) + k) % int'(NUM_CHANNELS);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
        pick_len = (remain_q[pick] > LEN_WIDTH'(MAX_SEGMENT)) ? LEN_WIDTH'(MAX_SEGMENT)
                                                               : remain_q[pick];
    end

    assign data_xfer = ((state_q == StWrite) && ch_write_enable[grant_q] && mem_write_ready) ||
                       ((state_q == StRead) && mem_read_enable && ch_read_ready[grant_q]);
    assign seg_done  = data_xfer && (count_q == seg_len_q - 1'b1);

    always_comb begin
        mem_cmd_enable   = 1'b0;
        mem_cmd_data     = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        ch_write_ready   = '0;
        mem_read_ready   = 1'b0;
        ch_read_enable   = '0;
        ch_read_data     = '0;
        unique case (state_q)
            StIssue: begin
                mem_cmd_enable = 1'b1;
                mem_cmd_data   = {rnw_q[grant_q], addr_q[grant_q], seg_len_q};
            end
            StWrite: begin
                mem_write_enable        = ch_write_enable[grant_q];
                mem_write_data          = ch_write_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
                ch_write_ready[grant_q] = mem_write_ready;
            end
            StRead: begin
                ch_read_enable[grant_q] = mem_read_enable;
                ch_read_data            = mem_read_data;
                mem_read_ready          = ch_read_ready[grant_q];
            end
            default: ;
        endcase
    end

    assign grant_valid = (state_q != StArb);
    assign grant_index = grant_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StArb;
            running_q    <= 1'b0;
            pending_q    <= '0;
            rnw_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CHANNELS - 1);
            seg_len_q    <= '0;
            count_q      <= '0;
            for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                addr_q[i]   <= '0;
                remain_q[i] <= '0;
            end
        end else begin
            running_q <= 1'b1;
            // Only non-pending channels are ready, so this never collides with the clear below.
            for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                if (ch_cmd_enable[i] && ch_cmd_ready[i] &&
                    (ch_cmd_data[i*CW +: LEN_WIDTH] != '0)) begin
                    pending_q[i] <= 1'b1;
                    rnw_q[i]     <= ch_cmd_data[i*CW + CW - 1];
                    addr_q[i]    <= ch_cmd_data[i*CW + LEN_WIDTH +: ADDR_WIDTH];
                    remain_q[i]  <= ch_cmd_data[i*CW +: LEN_WIDTH];
                end
            end
            unique case (state_q)
                StArb: begin
                    if (found) begin
                        grant_q   <= pick;
                        seg_len_q <= pick_len;
                        count_q   <= '0;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    if (mem_cmd_ready) begin
                        state_q <= rnw_q[grant_q] ? StRead : StWrite;
                    end
                end
                StWrite, StRead: begin
                    if (seg_done) begin
                        addr_q[grant_q]   <= addr_q[grant_q] + ADDR_WIDTH'(seg_len_q);
                        remain_q[grant_q] <= remain_q[grant_q] - seg_len_q;
                        if (remain_q[grant_q] == seg_len_q) begin
                            pending_q[grant_q] <= 1'b0;
                        end
                        last_grant_q <= grant_q;
                        state_q      <= StArb;
                    end else if (data_xfer) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: a default instance plus a MAX_SEGMENT=32 instance
// sharing all inputs, used for the address wrap scenario.
module tb_mem_channel_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int LW  = 32;
    localparam int CW  = 1 + AW + LW;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    ch_cmd_enable, ch_cmd_ready, ch_write_enable, ch_write_ready;
    logic [NCH*CW-1:0] ch_cmd_data;
    logic [NCH*DW-1:0] ch_write_data;
    logic [NCH-1:0]    ch_read_enable, ch_read_ready;
    logic [DW-1:0]     ch_read_data, mem_write_data, mem_read_data;
    logic              mem_cmd_enable, mem_cmd_ready, mem_write_enable, mem_write_ready;
    logic [CW-1:0]     mem_cmd_data;
    logic              mem_read_enable, mem_read_ready, grant_valid;
    logic [1:0]        grant_index;

    logic [NCH-1:0]    ch_cmd_ready_b, ch_write_ready_b, ch_read_enable_b;
    logic [DW-1:0]     ch_read_data_b, mem_write_data_b;
    logic              mem_cmd_enable_b, mem_write_enable_b, mem_read_ready_b, grant_valid_b;
    logic [CW-1:0]     mem_cmd_data_b;
    logic [1:0]        grant_index_b;

    int                tests = 0;
    int                fails = 0;
    logic [DW-1:0]     val = 8'h00;

    always #5 clk = ~clk;

    mem_channel_arbiter u_dut (
        .clk(clk), .reset(reset),
        .ch_cmd_enable(ch_cmd_enable), .ch_cmd_ready(ch_cmd_ready), .ch_cmd_data(ch_cmd_data),
        .ch_write_enable(ch_write_enable), .ch_write_ready(ch_write_ready),
        .ch_write_data(ch_write_data),
        .ch_read_enable(ch_read_enable), .ch_read_ready(ch_read_ready),
        .ch_read_data(ch_read_data),
        .mem_cmd_enable(mem_cmd_enable), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_data(mem_cmd_data),
        .mem_write_enable(mem_write_enable), .mem_write_ready(mem_write_ready),
        .mem_write_data(mem_write_data),
        .mem_read_enable(mem_read_enable), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .grant_valid(grant_valid), .grant_index(grant_index)
    );

    mem_channel_arbiter #(.MAX_SEGMENT(32)) u_dut_b (
        .clk(clk), .reset(reset),
        .ch_cmd_enable(ch_cmd_enable), .ch_cmd_ready(ch_cmd_ready_b), .ch_cmd_data(ch_cmd_data),
        .ch_write_enable(ch_write_enable), .ch_write_ready(ch_write_ready_b),
        .ch_write_data(ch_write_data),
        .ch_read_enable(ch_read_enable_b), .ch_read_ready(ch_read_ready),
        .ch_read_data(ch_read_data_b),
        .mem_cmd_enable(mem_cmd_enable_b), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_data(mem_cmd_data_b),
        .mem_write_enable(mem_write_enable_b), .mem_write_ready(mem_write_ready),
        .mem_write_data(mem_write_data_b),
        .mem_read_enable(mem_read_enable), .mem_read_ready(mem_read_ready_b),
        .mem_read_data(mem_read_data),
        .grant_valid(grant_valid_b), .grant_index(grant_index_b)
    );

    task automatic clear_inputs();
        ch_cmd_enable = '0; ch_cmd_data = '0; ch_write_enable = '0; ch_write_data = '0;
        ch_read_ready = '0; mem_cmd_ready = 1'b0; mem_write_ready = 1'b0;
        mem_read_enable = 1'b0; mem_read_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_cmd(input int ch, input logic rnw, input logic [AW-1:0] a,
                            input logic [LW-1:0] l, output bit ok);
        int t = 0;
        @(negedge clk);
        ch_cmd_enable[ch] = 1'b1;
        ch_cmd_data[ch*CW +: CW] = {rnw, a, l};
        #1;
        while (!ch_cmd_ready[ch] && t < 100) begin
            @(negedge clk); #1; t++;
        end
        ok = ch_cmd_ready[ch];
        @(posedge clk); #1;
        ch_cmd_enable[ch] = 1'b0;
    endtask

    // Downstream memory model: accepts one command, then moves exactly its length in words.
    task automatic serve(input bit bp, output logic [CW-1:0] cmd, output int gidx,
                         output int words, output int errs, output logic gv_after);
        int t; int len; bit rnw; int g; bit mx; bit cx;
        cmd = '0; gidx = -1; words = 0; errs = 0; gv_after = 1'b1; t = 0;
        @(negedge clk); #1;
        while (!mem_cmd_enable && t < 300) begin
            @(negedge clk); #1; t++;
        end
        if (!mem_cmd_enable) return;
        cmd  = mem_cmd_data;
        g    = int'(grant_index);
        gidx = grant_valid ? g : -1;
        rnw  = cmd[CW-1];
        len  = int'(cmd[LW-1:0]);
        mem_cmd_ready = 1'b1;
        t = 0;
        while (words < len && t < 3000) begin
            @(negedge clk);
            mem_cmd_ready = 1'b0;
            if (rnw) begin
                mem_read_enable = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_read_data   = val;
                ch_read_ready   = bp ? NCH'($urandom) : {NCH{1'b1}};
            end else begin
                ch_write_enable    = '0;
                ch_write_enable[g] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                ch_write_data      = '0;
                ch_write_data[g*DW +: DW] = val;
                mem_write_ready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1; t++;
            for (int i = 0; i < NCH; i++) begin
                if (i != g && (ch_read_enable[i] || ch_write_ready[i])) errs++;
            end
            if (!grant_valid || int'(grant_index) != g) begin
                errs++;
                break;
            end
            if (rnw) begin
                mx = mem_read_enable && mem_read_ready;
                cx = ch_read_enable[g] && ch_read_ready[g];
                if (mx && ch_read_data !== val) errs++;
            end else begin
                mx = mem_write_enable && mem_write_ready;
                cx = ch_write_enable[g] && ch_write_ready[g];
                if (mx && mem_write_data !== val) errs++;
            end
            if (mx != cx) errs++;
            if (mx) begin
                val++;
                words++;
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        gv_after = grant_valid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        ch_cmd_enable = '1; ch_write_enable = '1; ch_read_ready = '1;
        mem_cmd_ready = 1'b1; mem_write_ready = 1'b1; mem_read_enable = 1'b1;
        #1;
        tests++; if (ch_cmd_ready !== '0) begin
            fails++; $display("FAIL rst_ch_cmd_ready got %h want 0", ch_cmd_ready); end
        tests++; if (ch_write_ready !== '0) begin
            fails++; $display("FAIL rst_ch_write_ready got %h want 0", ch_write_ready); end
        tests++; if (ch_read_enable !== '0) begin
            fails++; $display("FAIL rst_ch_read_enable got %h want 0", ch_read_enable); end
        tests++; if (mem_cmd_enable !== 1'b0) begin
            fails++; $display("FAIL rst_mem_cmd_enable got %b want 0", mem_cmd_enable); end
        tests++; if (mem_cmd_data !== '0) begin
            fails++; $display("FAIL rst_mem_cmd_data got %h want 0", mem_cmd_data); end
        tests++; if (mem_write_enable !== 1'b0) begin
            fails++; $display("FAIL rst_mem_write_enable got %b want 0", mem_write_enable); end
        tests++; if (mem_read_ready !== 1'b0) begin
            fails++; $display("FAIL rst_mem_read_ready got %b want 0", mem_read_ready); end
        tests++; if (grant_valid !== 1'b0 || grant_index !== 2'd0) begin
            fails++; $display("FAIL rst_grant got %b/%0d want 0/0", grant_valid, grant_index); end
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        #1;
        tests++; if (ch_cmd_ready !== 4'h0) begin
            fails++; $display("FAIL rel_ready_early got %h want 0", ch_cmd_ready); end
        @(negedge clk); #1;
        tests++; if (ch_cmd_ready !== 4'hF) begin
            fails++; $display("FAIL rel_ready_late got %h want f", ch_cmd_ready); end
    endtask

    task automatic test_single_write();
        bit ok; logic [CW-1:0] cmd; int g, w, e; logic gv;
        logic [CW-1:0] exp_cmd = {1'b0, 32'h0000_0100, 32'd3};
        do_reset();
        send_cmd(1, 1'b0, 32'h100, 32'd3, ok);
        tests++; if (!ok) begin fails++; $display("FAIL sw_cmd_accept got 0 want 1"); end
        serve(1'b0, cmd, g, w, e, gv);
        tests++; if (cmd !== exp_cmd) begin
            fails++; $display("FAIL sw_mem_cmd got %h want %h", cmd, exp_cmd); end
        tests++; if (g != 1) begin fails++; $display("FAIL sw_grant got %0d want 1", g); end
        tests++; if (w != 3) begin fails++; $display("FAIL sw_words got %0d want 3", w); end
        tests++; if (e != 0) begin fails++; $display("FAIL sw_data_errs got %0d want 0", e); end
        tests++; if (gv !== 1'b0) begin
            fails++; $display("FAIL sw_grant_fall got %b want 0", gv); end
        tests++; if (ch_cmd_ready[1] !== 1'b1) begin
            fails++; $display("FAIL sw_ready_again got %b want 1", ch_cmd_ready[1]); end
    endtask

    task automatic test_split_read();
        bit ok; logic [CW-1:0] cmd; int g, w, e, total; logic gv;
        logic [AW-1:0] exp_a [3] = '{32'h0, 32'h40, 32'h80};
        logic [LW-1:0] exp_l [3] = '{32'd64, 32'd64, 32'd22};
        total = 0;
        do_reset();
        mem_read_enable = 1'b1;
        send_cmd(0, 1'b1, 32'h0, 32'd150, ok);
        tests++; if (!ok) begin fails++; $display("FAIL sr_cmd_accept got 0 want 1"); end
        tests++; if (mem_read_ready !== 1'b0) begin
            fails++; $display("FAIL sr_stall_outside_read got %b want 0", mem_read_ready); end
        for (int s = 0; s < 3; s++) begin
            serve(1'b0, cmd, g, w, e, gv);
            total += w;
            tests++; if (cmd !== {1'b1, exp_a[s], exp_l[s]}) begin
                fails++; $display("FAIL sr_seg%0d_cmd got %h want %h", s, cmd,
                                  {1'b1, exp_a[s], exp_l[s]}); end
            tests++; if (g != 0 || e != 0) begin
                fails++; $display("FAIL sr_seg%0d grant %0d errs %0d want 0 0", s, g, e); end
        end
        tests++; if (total != 150) begin
            fails++; $display("FAIL sr_total_words got %0d want 150", total); end
        tests++; if (ch_cmd_ready[0] !== 1'b1) begin
            fails++; $display("FAIL sr_ready_again got %b want 1", ch_cmd_ready[0]); end
    endtask

    task automatic test_fairness();
        bit ok0, ok2; logic [CW-1:0] cmd; int g, w, e; logic gv;
        int exp_g [4] = '{0, 2, 0, 2};
        logic [AW-1:0] exp_a [4] = '{32'h1000, 32'h2000, 32'h1040, 32'h2040};
        do_reset();
        send_cmd(0, 1'b1, 32'h1000, 32'd128, ok0);
        send_cmd(2, 1'b1, 32'h2000, 32'd128, ok2);
        tests++; if (!ok0 || !ok2) begin
            fails++; $display("FAIL fair_cmd_accept got %b%b want 11", ok0, ok2); end
        for (int s = 0; s < 4; s++) begin
            serve(1'b0, cmd, g, w, e, gv);
            tests++; if (g != exp_g[s]) begin
                fails++; $display("FAIL fair_seg%0d_grant got %0d want %0d", s, g, exp_g[s]); end
            tests++; if (cmd !== {1'b1, exp_a[s], 32'd64}) begin
                fails++; $display("FAIL fair_seg%0d_cmd got %h want %h", s, cmd,
                                  {1'b1, exp_a[s], 32'd64}); end
            tests++; if (w != 64 || e != 0) begin
                fails++; $display("FAIL fair_seg%0d words %0d errs %0d want 64 0", s, w, e); end
        end
    endtask

    task automatic test_backpressure();
        bit ok; logic [CW-1:0] cmd; int g, w, e; logic gv;
        do_reset();
        send_cmd(1, 1'b1, 32'h300, 32'd40, ok);
        serve(1'b1, cmd, g, w, e, gv);
        tests++; if (!ok || cmd !== {1'b1, 32'h300, 32'd40}) begin
            fails++; $display("FAIL bp_rd_cmd got %h want %h", cmd, {1'b1, 32'h300, 32'd40}); end
        tests++; if (g != 1 || w != 40 || e != 0) begin
            fails++; $display("FAIL bp_rd grant %0d words %0d errs %0d want 1 40 0", g, w, e); end
        send_cmd(3, 1'b0, 32'h400, 32'd20, ok);
        serve(1'b1, cmd, g, w, e, gv);
        tests++; if (!ok || cmd !== {1'b0, 32'h400, 32'd20}) begin
            fails++; $display("FAIL bp_wr_cmd got %h want %h", cmd, {1'b0, 32'h400, 32'd20}); end
        tests++; if (g != 3 || w != 20 || e != 0) begin
            fails++; $display("FAIL bp_wr grant %0d words %0d errs %0d want 3 20 0", g, w, e); end
    endtask

    task automatic test_zero_and_wrap();
        bit ok; int ncmd, nb, nw, errs;
        logic [CW-1:0] cmds_b [2];
        do_reset();
        send_cmd(3, 1'b0, 32'h55, 32'd0, ok);
        ncmd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (mem_cmd_enable || grant_valid) ncmd++;
        end
        tests++; if (!ok || ncmd != 0) begin
            fails++; $display("FAIL zero_len_cmds got %0d want 0", ncmd); end
        tests++; if (ch_cmd_ready[3] !== 1'b1) begin
            fails++; $display("FAIL zero_len_ready got %b want 1", ch_cmd_ready[3]); end

        do_reset();
        mem_cmd_ready = 1'b1; mem_write_ready = 1'b1;
        ch_write_enable[0] = 1'b1; ch_write_data[DW-1:0] = 8'hA5;
        send_cmd(0, 1'b0, 32'hFFFF_FFE0, 32'd64, ok);
        nb = 0; nw = 0; errs = 0;
        cmds_b[0] = '0; cmds_b[1] = '0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk); #1;
            if (mem_cmd_enable_b) begin
                if (nb < 2) cmds_b[nb] = mem_cmd_data_b;
                nb++;
            end
            if (mem_write_enable_b) begin
                nw++;
                if (mem_write_data_b !== 8'hA5) errs++;
            end
            if (ch_write_ready_b !== {3'b000, mem_write_enable_b & mem_write_ready}) errs++;
            if (ch_read_enable_b !== '0 || mem_read_ready_b || ch_read_data_b !== '0) errs++;
            if (grant_valid_b && grant_index_b !== 2'd0) errs++;
        end
        tests++; if (!ok || nb != 2) begin
            fails++; $display("FAIL wrap_seg_count got %0d want 2", nb); end
        tests++; if (cmds_b[0] !== {1'b0, 32'hFFFF_FFE0, 32'd32}) begin
            fails++; $display("FAIL wrap_seg0 got %h want %h", cmds_b[0],
                              {1'b0, 32'hFFFF_FFE0, 32'd32}); end
        tests++; if (cmds_b[1] !== {1'b0, 32'h0, 32'd32}) begin
            fails++; $display("FAIL wrap_seg1 got %h want %h", cmds_b[1],
                              {1'b0, 32'h0, 32'd32}); end
        tests++; if (nw != 64 || errs != 0) begin
            fails++; $display("FAIL wrap_words got %0d errs %0d want 64 0", nw, errs); end
        tests++; if (grant_valid_b !== 1'b0 || ch_cmd_ready_b[0] !== 1'b1) begin
            fails++; $display("FAIL wrap_end gv %b ready %b want 0 1",
                              grant_valid_b, ch_cmd_ready_b[0]); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_write();
        bit ok; int nw, ncmd;
        do_reset();
        send_cmd(2, 1'b0, 32'h200, 32'd10, ok);
        nw = 0;
        for (int c = 0; c < 30 && nw < 3; c++) begin
            @(negedge clk);
            mem_cmd_ready = 1'b1; mem_write_ready = 1'b1; ch_write_enable[2] = 1'b1;
            #1;
            if (mem_write_enable) nw++;
        end
        tests++; if (!ok || nw != 3) begin
            fails++; $display("FAIL mid_reach_write got %0d want 3", nw); end
        reset = 1'b0;
        #1;
        tests++; if (mem_write_enable !== 1'b0 || ch_write_ready !== '0) begin
            fails++; $display("FAIL mid_rst_write got %b/%h want 0/0",
                              mem_write_enable, ch_write_ready); end
        tests++; if (grant_valid !== 1'b0 || mem_cmd_enable !== 1'b0 || ch_cmd_ready !== '0)
        begin
            fails++; $display("FAIL mid_rst_ctrl got %b %b %h want 0 0 0",
                              grant_valid, mem_cmd_enable, ch_cmd_ready); end
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        #1;
        tests++; if (ch_cmd_ready !== 4'h0) begin
            fails++; $display("FAIL mid_rel_first got %h want 0", ch_cmd_ready); end
        @(negedge clk); #1;
        tests++; if (ch_cmd_ready !== 4'hF) begin
            fails++; $display("FAIL mid_rel_second got %h want f", ch_cmd_ready); end
        ncmd = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (mem_cmd_enable) ncmd++;
        end
        tests++; if (ncmd != 0) begin
            fails++; $display("FAIL mid_abandoned got %0d cmds want 0", ncmd); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_split_read();
        test_fairness();
        test_backpressure();
        test_zero_and_wrap();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_channel_arbiter.md
MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of client channels (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, word address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 32, command length width, counted in words.
REQ-005 SHALL have parameter MAX_SEGMENT, default 64, maximum words per downstream command (power of 2, at least 1).
REQ-006 SHALL have these ports, with CW = 1+ADDR_WIDTH+LEN_WIDTH and command layout {read_not_write, address, length}, MSB first:
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- ch_cmd_enable / ch_cmd_ready  in / out  NUM_CHANNELS  per-channel command handshake.
- ch_cmd_data  in  NUM_CHANNELS*CW  per-channel command; channel i occupies bits [i*CW +: CW].
- ch_write_enable / ch_write_ready  in / out  NUM_CHANNELS  per-channel write data handshake.
- ch_write_data  in  NUM_CHANNELS*DATA_WIDTH  per-channel write data.
- ch_read_enable / ch_read_ready  out / in  NUM_CHANNELS  per-channel read data handshake.
- ch_read_data  out  DATA_WIDTH  read data, shared by all channels.
- mem_cmd_enable / mem_cmd_ready  out / in  1  downstream command handshake.
- mem_cmd_data  out  CW  downstream command.
- mem_write_enable / mem_write_ready  out / in  1  downstream write data handshake.
- mem_write_data  out  DATA_WIDTH  downstream write data.
- mem_read_enable / mem_read_ready  in / out  1  downstream read data handshake.
- mem_read_data  in  DATA_WIDTH  downstream read data.
- grant_valid  out  1  a segment is in progress.
- grant_index  out  $clog2(NUM_CHANNELS)  channel owning the segment in progress.

Function
REQ-007 SHALL treat a transfer on any handshake as occurring when enable and ready are both high on a rising clk edge.
REQ-008 SHALL hold, per channel, a one-entry pending command register (pending flag, address, remaining length).
REQ-009 SHALL drive ch_cmd_ready[i] = running && !pending[i], where running is a register that is 0 in reset and 1 from the first clk edge after reset release.
REQ-010 SHALL, on a command transfer with length 0, discard the command and leave pending[i] clear.
REQ-011 SHALL use a state machine with states ARB, ISSUE, WRITE, READ, and ARB as the reset state.
REQ-012 ARB: if any channel is pending, SHALL grant the first pending channel at or after (last_grant+1) mod NUM_CHANNELS, latch seg_len = min(remaining, MAX_SEGMENT), and go to ISSUE next cycle; last_grant resets to NUM_CHANNELS-1.
REQ-013 ISSUE: SHALL hold mem_cmd_enable=1 with {rnw, address, seg_len} until mem_cmd_ready; on transfer SHALL go to READ if rnw is 1, otherwise WRITE.
REQ-014 WRITE: SHALL pass data combinationally: mem_write_enable = ch_write_enable[g], mem_write_data = ch_write_data[g], ch_write_ready[g] = mem_write_ready; all other ch_write_ready SHALL be 0.
REQ-015 READ: SHALL drive ch_read_enable[g] = mem_read_enable, ch_read_data = mem_read_data, mem_read_ready = ch_read_ready[g]; all other ch_read_enable SHALL be 0.
REQ-016 SHALL drive mem_read_ready=0 outside READ and mem_write_enable=0 outside WRITE; read data arriving outside READ SHALL stall, never be dropped.
REQ-017 SHALL count data transfers in WRITE/READ; on the seg_len-th transfer it SHALL set address += seg_len (mod 2^ADDR_WIDTH), remaining -= seg_len, clear pending[g] if remaining reaches 0, set last_grant = g, and return to ARB.
REQ-018 SHALL allow a new command on channel i in the cycle after its pending flag clears; a command transfer on a non-granted channel SHALL be accepted concurrently with any state.
REQ-019 SHALL issue only one downstream segment at a time; a new segment is not issued until all data of the current segment has been transferred.
REQ-020 SHALL drive grant_valid=1 in ISSUE/WRITE/READ, with grant_index=g.

Reset
REQ-021 While reset is low, SHALL force: all pending flags clear, state ARB, running 0; every enable/ready output 0, mem_cmd_data 0, grant_valid 0, grant_index 0.
REQ-022 Reset assertion mid-segment SHALL abandon the segment immediately (asynchronously) without completing the handshake.

Verification
REQ-023 Single write: ch1 cmd {0, 0x100, 3} -> mem_cmd {0, 0x100, 3}; 3 words pass ch1->mem; grant_valid falls after the third word; ch1 ready again.
REQ-024 Split read: MAX_SEGMENT=64, ch0 cmd {1, 0x0, 150} -> mem_cmd lengths 64, 64, 22 at addresses 0x0, 0x40, 0x80; 150 words delivered to ch0 only.
REQ-025 Fairness: ch0 and ch2 each pending with 128-word reads -> segments alternate ch0, ch2, ch0, ch2.
REQ-026 Zero length and wrap: a length-0 cmd produces no mem_cmd; a cmd {0, 2^ADDR_WIDTH-32, 64} with MAX_SEGMENT=32 produces a second segment at address 0.
REQ-027 Backpressure: mem_read_ready/ch_read_ready toggled randomly -> no data lost or duplicated, and non-granted ch_read_enable stays 0.
REQ-028 Reset mid-write -> all outputs 0 while reset is low; ch_cmd_ready is 1 on the second edge after release.
